// File: rtl/mmio_led_timer.sv
// MMIO peripheral window: LED register, synchronized buttons, free-running timer (optional compare/irq via MMIO_TIMER_CMP_EN).
// Latency: mem_ready pulses for one cycle, WAIT_CYCLES+1 edges after mem_valid is first sampled with a window hit.
// Backpressure: one request at a time; after the ready pulse, mem_valid must be seen low before a new request is accepted.
module mmio_led_timer #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  LED_INIT    = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [7:0]  led,
    input  logic [6:0]  btn,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  reg_q, reg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [6:0]  btn_meta_q, btn_sync_q;
    logic [31:0] rd_mux;
    logic [31:0] cmp_rd;
    logic        hit;
    logic        commit;
    logic        is_write;
    logic        unused_addr_bits;

    // Byte offset bits carry no meaning for word registers.
    assign unused_addr_bits = ^mem_addr[1:0];

    assign hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign is_write = |wstrb_q;

    // Request sequencing: accept, count down the wait, respond once, then drain until valid drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid && hit) begin
                    reg_d   = mem_addr[3:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!mem_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read mux over the latched word offset.
    always_comb begin
        rd_mux = '0;
        case (reg_q)
            2'd0:    rd_mux = {24'b0, led_q};
            2'd1:    rd_mux = {25'b0, btn_sync_q};
            2'd2:    rd_mux = timer_q;
            default: rd_mux = cmp_rd;
        endcase
    end

    // Register updates: the timer always advances, a strobed write overrides individual bytes.
    always_comb begin
        led_d   = led_q;
        timer_d = timer_q + 32'd1;
        rdata_d = '0;
        if (commit && !is_write) begin
            rdata_d = rd_mux;
        end
        if (commit && is_write) begin
            if ((reg_q == 2'd0) && wstrb_q[0]) begin
                led_d = wdata_q[7:0];
            end
            if (reg_q == 2'd2) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) begin
                        timer_d[8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // State, request latches, registers and the button synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            led_q      <= LED_INIT;
            timer_q    <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            led_q      <= led_d;
            timer_q    <= timer_d;
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef MMIO_TIMER_CMP_EN
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
    logic        cmp_wr;

    // Compare register and sticky match flag; a CMP write clears the flag even on a simultaneous match.
    always_comb begin
        cmp_d  = cmp_q;
        cmp_wr = commit && is_write && (reg_q == 2'd3);
        irq_d  = irq_q | (timer_q == cmp_q);
        if (cmp_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    cmp_d[8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
            irq_d = 1'b0;
        end
    end

    // Compare state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_q <= 32'hFFFF_FFFF;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cmp_rd = cmp_q;
    assign irq    = irq_q;
`else
    assign cmp_rd = '0;
    assign irq    = 1'b0;
`endif

    assign mem_ready = (state_q == ST_RESP);
    assign mem_rdata = rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_mmio_led_timer.sv
// Bench for mmio_led_timer: directed register-map cases plus randomized transactions.
// Outputs are compared every cycle against a transaction-level model; literal checks pin the model.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_mmio_led_timer;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          W     = 1;
    localparam logic [7:0]  LINIT = 8'h00;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [6:0]  btn       = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  led;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mmio_led_timer #(
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(W),
        .LED_INIT   (LINIT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .led      (led),
        .btn      (btn),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  m_led   = LINIT;
    logic [31:0] m_timer = '0;
    logic [31:0] m_cmp   = 32'hFFFF_FFFF;
    logic        m_irq   = 1'b0;
    logic [6:0]  m_hist1 = '0;   // btn as seen at the previous edge
    logic [6:0]  m_bsync = '0;   // btn as seen two edges ago
    bit          m_busy  = 0;
    bit          m_drain = 0;
    int          m_edge  = 0;
    int          m_resp  = 0;
    logic [31:0] m_a, m_wd;
    logic [3:0]  m_ws;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [31:0] t_next, c_next;
    logic [7:0]  l_next;
    bit          c_wr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_led = LINIT; m_timer = '0; m_cmp = 32'hFFFF_FFFF; m_irq = 1'b0;
            m_hist1 = '0; m_bsync = '0; m_busy = 0; m_drain = 0;
            m_ready = 1'b0; m_rdata = '0;
        end else begin
            m_edge++;
            t_next = m_timer + 32'd1;
            l_next = m_led;
            c_next = m_cmp;
            c_wr = 0;
            m_ready = 1'b0;
            m_rdata = '0;
            if (m_busy && !m_drain && m_edge == m_resp) begin
                m_ready = 1'b1;
                m_drain = 1;
                if (m_ws == 4'b0) begin
                    case (m_a[3:2])
                        2'd0: m_rdata = {24'b0, m_led};
                        2'd1: m_rdata = {25'b0, m_bsync};
                        2'd2: m_rdata = m_timer;
`ifdef MMIO_TIMER_CMP_EN
                        default: m_rdata = m_cmp;
`else
                        default: m_rdata = '0;
`endif
                    endcase
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_ws[b]) begin
                            if (m_a[3:2] == 2'd2) t_next[8*b +: 8] = m_wd[8*b +: 8];
                            if (m_a[3:2] == 2'd3) c_next[8*b +: 8] = m_wd[8*b +: 8];
                        end
                    end
                    if (m_a[3:2] == 2'd0 && m_ws[0]) l_next = m_wd[7:0];
                    if (m_a[3:2] == 2'd3) c_wr = 1;
                end
            end else if (m_drain) begin
                if (m_edge > m_resp + 1 && !mem_valid) begin
                    m_busy = 0;
                    m_drain = 0;
                end
            end else if (!m_busy && mem_valid && mem_addr[31:4] == BASE[31:4]) begin
                m_busy = 1;
                m_a = mem_addr; m_wd = mem_wdata; m_ws = mem_wstrb;
                m_resp = m_edge + W + 1;
            end
`ifdef MMIO_TIMER_CMP_EN
            m_irq = c_wr ? 1'b0 : (m_irq | (m_timer == m_cmp));
            m_cmp = c_next;
`else
            m_irq = 1'b0;
`endif
            m_timer = t_next;
            m_led = l_next;
            m_bsync = m_hist1;
            m_hist1 = btn;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("ready", {31'b0, mem_ready}, {31'b0, m_ready});
            check("rdata", mem_rdata, m_rdata);
            check("led", {24'b0, led}, {24'b0, m_led});
            check("irq", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    // One bus transaction; returns read data and the edge index of the ready cycle.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input bit early, input int hold,
                          output logic [31:0] rd, output int redge);
        int  start;
        int  extra;
        bit  got;
        got = 0; extra = 0; rd = '0; redge = -1;
        @(posedge clk); #2;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        start = cyc + 1;
        if (early) begin
            @(posedge clk); #2;
            mem_valid = 1'b0;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1; rd = mem_rdata; redge = cyc;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL txn_timeout: no ready for addr 0x%08h within 40 cycles", a);
        end else begin
            check("latency", 32'(redge - start), 32'(W + 1));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (mem_ready) extra++;
        end
        @(posedge clk); #2;
        mem_valid = 1'b0; mem_wstrb = '0;
        check("single_ready_pulse", 32'(extra), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int r1, r2, cnt;

        // Reset
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'b0, mem_ready}, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        check("reset_led", {24'b0, led}, {24'b0, LINIT});
        check("reset_irq", {31'b0, irq}, 32'd0);

        // LED read / write / partial write
        do_txn(BASE, 32'h0, 4'b0000, 0, 0, rd, r1);
        check("led_read_reset", rd, 32'h0000_0000);
        do_txn(BASE, 32'hDEAD_BEAA, 4'b0001, 0, 0, rd, r1);
        check("led_write_rdata", rd, 32'h0);
        check("led_after_write", {24'b0, led}, 32'h0000_00AA);
        do_txn(BASE, 32'hDEAD_BE55, 4'b0010, 0, 0, rd, r1);
        check("led_partial_nochange", {24'b0, led}, 32'h0000_00AA);
        do_txn(BASE, 32'h0, 4'b0000, 0, 0, rd, r1);
        check("led_readback", rd, 32'h0000_00AA);

        // Buttons
        @(posedge clk); #2 btn = 7'b101_0011;
        repeat (4) @(posedge clk);
        do_txn(BASE + 32'h4, 32'h0, 4'b0000, 0, 0, rd, r1);
        check("btn_read", rd, 32'h0000_0053);
        do_txn(BASE + 32'h4, 32'hFF, 4'b1111, 0, 0, rd, r1);
        check("btn_write_rdata", rd, 32'h0);
        do_txn(BASE + 32'h4, 32'h0, 4'b0000, 0, 0, rd, r1);
        check("btn_read_after_write", rd, 32'h0000_0053);

        // Timer wrap
        do_txn(BASE + 32'h8, 32'hFFFF_FFFE, 4'b1111, 0, 0, rd, r1);
        repeat (3) @(posedge clk);
        do_txn(BASE + 32'h8, 32'h0, 4'b0000, 0, 0, rd, r2);
        check("timer_wrap", rd, 32'hFFFF_FFFE + 32'(r2 - r1 - 1));
        check("timer_wrapped_small", {31'b0, rd < 32'h20}, 32'd1);

        // Window miss held 20 cycles
        @(posedge clk); #2;
        mem_valid = 1'b1; mem_addr = 32'h2000_0000; mem_wstrb = 4'b0000;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_ready) cnt++;
        end
        @(posedge clk); #2 mem_valid = 1'b0;
        check("miss_no_ready", 32'(cnt), 32'd0);

        // Valid held after ready: single pulse (checked in task)
        do_txn(BASE, 32'h0, 4'b0000, 0, 6, rd, r1);
        check("hold_read", rd, 32'h0000_00AA);

        // Protocol violation: valid dropped early still completes
        do_txn(BASE, 32'h0000_0033, 4'b0001, 1, 0, rd, r1);
        check("early_drop_led", {24'b0, led}, 32'h0000_0033);

`ifdef MMIO_TIMER_CMP_EN
        do_txn(BASE + 32'h8, 32'h0000_1000, 4'b1111, 0, 0, rd, r1);
        do_txn(BASE + 32'hC, 32'h0000_0010, 4'b1111, 0, 0, rd, r1);
        do_txn(BASE + 32'hC, 32'h0, 4'b0000, 0, 0, rd, r1);
        check("cmp_read", rd, 32'h0000_0010);
        do_txn(BASE + 32'h8, 32'h0, 4'b1111, 0, 0, rd, r1);
        check("irq_before_match", {31'b0, irq}, 32'd0);
        r2 = -1;
        for (int i = 0; i < 40 && r2 < 0; i++) begin
            @(negedge clk);
            if (irq) r2 = cyc;
        end
        check("irq_rise_edge", 32'(r2 - r1), 32'd17);
        do_txn(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111, 0, 0, rd, r1);
        check("irq_cleared", {31'b0, irq}, 32'd0);
`else
        do_txn(BASE + 32'hC, 32'h1234_5678, 4'b1111, 0, 0, rd, r1);
        do_txn(BASE + 32'hC, 32'h0, 4'b0000, 0, 0, rd, r1);
        check("cmp_absent_read", rd, 32'h0);
        check("irq_tied", {31'b0, irq}, 32'd0);
`endif

        // Reset asserted while waiting: aborted, no write, no ready
        @(posedge clk); #2;
        mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'h55; mem_wstrb = 4'b0001;
        @(posedge clk); #2;
        reset_n = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'b0000;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (mem_ready) cnt++; end
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (5) begin @(negedge clk); if (mem_ready) cnt++; end
        check("reset_abort_no_ready", 32'(cnt), 32'd0);
        check("reset_abort_led", {24'b0, led}, {24'b0, LINIT});

        // Randomized traffic, checked by the per-cycle model comparison
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [3:0]  ws;
            int          kind;
            kind = $urandom_range(0, 9);
            @(posedge clk); #2 btn = 7'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if (kind == 0) begin
                @(posedge clk); #2;
                mem_valid = 1'b1; mem_addr = 32'h2000_0000 | ($urandom & 32'h00FF_FFFC);
                mem_wstrb = 4'($urandom);
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #2 mem_valid = 1'b0; mem_wstrb = '0;
            end else begin
                a  = BASE + {28'b0, 2'($urandom), 2'($urandom)};
                ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                do_txn(a, $urandom, ws, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), rd, r1);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
